// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage valid/ready AES SubBytes / InvSubBytes engine, LANES bytes per transaction.
// Stage 1 holds the raw input; stage 2 holds the substituted bytes presented downstream.
module aes_sub_bytes_pipe #(
   parameter int unsigned LANES = 16,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   input  logic                 in_inv,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data,
   output logic                 out_inv,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int unsigned W = 8 * LANES;

   logic             s1_valid_q, s1_valid_d;
   logic [W-1:0]     s1_data_q,  s1_data_d;
   logic             s1_inv_q,   s1_inv_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
   logic             s2_valid_q, s2_valid_d;
   logic [W-1:0]     s2_data_q,  s2_data_d;
   logic             s2_inv_q,   s2_inv_d;
   logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

   logic             s2_load;
   logic             in_acc;
   logic [W-1:0]     lookup;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] y;
      logic [7:0] sq;
      y  = 8'h01;
      sq = x;
      for (int unsigned i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         y  = gf_mul(y, sq);
      end
      return y;
   endfunction

   // The forward and inverse boxes share one field inverter; only the affine step moves.
   function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
      logic [7:0] pre;
      logic [7:0] y;
      if (inv)
         pre = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      else
         pre = x;
      y = gf_inv(pre);
      if (inv)
         return y;
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready = ~flush & (~s1_valid_q | s2_load);
   assign in_acc   = in_valid & in_ready;

   always_comb begin
      lookup = '0;
      for (int unsigned k = 0; k < LANES; k++)
         lookup[8*k +: 8] = sub_byte(s1_data_q[8*k +: 8], s1_inv_q);
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_inv_d   = s1_inv_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_inv_d   = s2_inv_q;
      s2_tag_d   = s2_tag_q;

      // Payload only loads on a real accept, so X on idle inputs never reaches state.
      if (in_acc) begin
         s1_data_d = in_data;
         s1_inv_d  = in_inv;
         s1_tag_d  = in_tag;
      end
      if (s2_load) begin
         s2_data_d = lookup;
         s2_inv_d  = s1_inv_q;
         s2_tag_d  = s1_tag_q;
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (in_acc)
            s1_valid_d = 1'b1;
         else if (s2_load)
            s1_valid_d = 1'b0;
         if (s2_load)
            s2_valid_d = 1'b1;
         else if (out_ready)
            s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_inv_q   <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_inv_q   <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_inv_q   <= s1_inv_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_inv_q   <= s2_inv_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_inv   = s2_inv_q;
   assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Directed bench for aes_sub_bytes_pipe: FIPS-197 vectors, round trip, backpressure, flush, reset.
module tb_aes_sub_bytes_pipe;

   localparam int unsigned LANES = 16;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned W     = 8 * LANES;

   // Forward vector, lanes 15..0, and its hand-looked-up S-box image.
   localparam logic [W-1:0] FV = {8'h0f, 8'hf0, 8'h1f, 8'h11, 8'h03, 8'h02, 8'h8c, 8'h10,
                                  8'hff, 8'h01, 8'h53, 8'h00, 8'hbe, 8'he3, 8'h3d, 8'h19};
   localparam logic [W-1:0] FE = {8'h76, 8'h8c, 8'hc0, 8'h82, 8'h7b, 8'h77, 8'h64, 8'hca,
                                  8'h16, 8'h7c, 8'hed, 8'h63, 8'hae, 8'h11, 8'h27, 8'hd4};
   localparam logic [W-1:0] IV = {{8{8'h00}}, 8'h8c, 8'h7c, 8'h16, 8'hd4, 8'hed, 8'h52, 8'h63, 8'h00};
   localparam logic [W-1:0] IE = {{8{8'h52}}, 8'hf0, 8'h01, 8'hff, 8'h19, 8'h53, 8'h48, 8'h00, 8'h52};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic             in_inv = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [W-1:0]     out_data;
   logic             out_inv;
   logic [TAG_W-1:0] out_tag;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aes_sub_bytes_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
      .out_tag(out_tag)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_data = FV; in_tag = 4'h7; in_inv = 1'b1; out_ready = 1'b1;
      tick(); tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
      checks++; if (out_tag !== '0 || out_inv !== 1'b0) begin errors++; $display("FAIL rst_tag_inv: got %h/%b want 0/0", out_tag, out_inv); end
      rst_n = 1'b1; in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_post_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_fwd();
      out_ready = 1'b1; in_valid = 1'b1; in_data = FV; in_inv = 1'b0; in_tag = 4'h5;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_in_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_early: got %b want 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== FE) begin errors++; $display("FAIL fwd_data: got %h want %h", out_data, FE); end
      checks++; if (out_tag !== 4'h5 || out_inv !== 1'b0) begin errors++; $display("FAIL fwd_tag_inv: got %h/%b want 5/0", out_tag, out_inv); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_inv();
      out_ready = 1'b1; in_valid = 1'b1; in_data = IV; in_inv = 1'b1; in_tag = 4'ha;
      tick();
      in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inv_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== IE) begin errors++; $display("FAIL inv_data: got %h want %h", out_data, IE); end
      checks++; if (out_tag !== 4'ha || out_inv !== 1'b1) begin errors++; $display("FAIL inv_tag_inv: got %h/%b want a/1", out_tag, out_inv); end
      tick();
   endtask

   task automatic test_round_trip();
      logic [W-1:0] fw [16];
      logic [W-1:0] orig;
      int got;
      out_ready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         got = 0;
         for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid === 1'b1) begin
               checks++; if (got >= 16 || out_tag !== TAG_W'(got) || out_inv !== 1'(pass)) begin
                  errors++; $display("FAIL rt_tag_inv: got %h/%b want %h/%0d", out_tag, out_inv, got, pass);
               end
               if (got < 16) begin
                  if (pass == 0) fw[got] = out_data;
                  else begin
                     for (int j = 0; j < 16; j++) orig[8*j +: 8] = 8'(16 * got + j);
                     checks++; if (out_data !== orig) begin errors++; $display("FAIL rt_identity: got %h want %h", out_data, orig); end
                  end
               end
               got++;
            end
            if (cyc < 16) begin
               in_valid = 1'b1; in_inv = 1'(pass); in_tag = TAG_W'(cyc);
               if (pass == 0) for (int j = 0; j < 16; j++) in_data[8*j +: 8] = 8'(16 * cyc + j);
               else in_data = fw[cyc];
            end else begin
               in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
            end
            tick();
         end
         checks++; if (got != 16) begin errors++; $display("FAIL rt_count: got %0d want 16", got); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_d;
      int got, first, last;
      got = 0; first = -1; last = -1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (out_valid === 1'b1) begin
            exp_d = got[0] ? IE : FE;
            checks++; if (got >= 4 || out_data !== exp_d || out_tag !== TAG_W'(got + 1) || out_inv !== got[0]) begin
               errors++; $display("FAIL b2b_out: got %h/%h want %h/%h", out_data, out_tag, exp_d, got + 1);
            end
            if (first < 0) first = cyc;
            last = cyc; got++;
         end
         if (cyc < 4) begin
            in_valid = 1'b1; in_inv = cyc[0]; in_data = cyc[0] ? IV : FV; in_tag = TAG_W'(cyc + 1);
         end else begin
            in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
         end
         tick();
      end
      checks++; if (got != 4 || last - first != 3) begin errors++; $display("FAIL b2b_bubbles: got %0d in span %0d want 4 in 3", got, last - first); end
   endtask

   task automatic test_backpressure();
      logic [7:0] bp_in  [8] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'h00, 8'h53, 8'h01, 8'hff};
      logic [7:0] bp_out [8] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'h63, 8'hed, 8'h7c, 8'h16};
      logic [W-1:0] held_d;
      logic [TAG_W-1:0] held_t;
      logic held, exp_rdy, acc, xfer;
      int occ, sent, rcv, stalls;
      occ = 0; sent = 0; rcv = 0; stalls = 0; held = 1'b0;
      for (int cyc = 0; cyc < 64 && rcv < 8; cyc++) begin
         if (held) begin
            checks++; if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
               errors++; $display("FAIL bp_stable: got %b/%h/%h want 1/%h/%h", out_valid, out_data, out_tag, held_d, held_t);
            end
         end
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (sent < 8) begin
            in_valid = 1'b1; in_inv = 1'b0; in_tag = TAG_W'(sent); in_data = {16{bp_in[sent]}};
         end else begin
            in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
         end
         #1;
         exp_rdy = !(occ == 2 && !out_ready);
         if (!exp_rdy) stalls++;
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready: got %b want %b cyc %0d", in_ready, exp_rdy, cyc); end
         acc  = in_valid && exp_rdy;
         xfer = (out_valid === 1'b1) && out_ready;
         if (xfer) begin
            checks++; if (out_tag !== TAG_W'(rcv) || out_data !== {16{bp_out[rcv]}}) begin
               errors++; $display("FAIL bp_order: got %h/%h want %h/%h", out_tag, out_data, rcv, {16{bp_out[rcv]}});
            end
            rcv++;
         end
         held   = (out_valid === 1'b1) && !out_ready;
         held_d = out_data; held_t = out_tag;
         occ    = occ + int'(acc) - int'(xfer);
         if (acc) sent++;
         tick();
      end
      checks++; if (rcv != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", rcv); end
      checks++; if (stalls == 0) begin errors++; $display("FAIL bp_no_stall: got %0d want >0", stalls); end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inv = 1'b0; in_data = FV; in_tag = 4'h9;
      tick();
      in_tag = 4'ha;
      tick();
      flush = 1'b1; in_tag = 4'hc; in_data = IV; in_inv = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'h9) begin errors++; $display("FAIL fl_full: got %b/%h want 1/9", out_valid, out_tag); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready: got %b want 0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_cleared: got %b want 0", out_valid); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_leak: got %b/%h want 0", out_valid, out_tag); end
      end
      in_valid = 1'b1; in_data = FV; in_inv = 1'b0; in_tag = 4'hd;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_resume_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
      tick();
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'hd || out_data !== FE) begin
         errors++; $display("FAIL fl_resume: got %b/%h/%h want 1/d/%h", out_valid, out_tag, out_data, FE);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inv = 1'b0; in_data = FV; in_tag = 4'h3;
      tick();
      in_tag = 4'h4;
      tick();
      in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_full: got %b want 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
         errors++; $display("FAIL rm_async: got %b/%h/%h want 0/0/0", out_valid, out_data, out_tag);
      end
      tick(); tick();
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_leak: got %b/%h want 0", out_valid, out_tag); end
      end
      in_valid = 1'b1; in_data = IV; in_inv = 1'b1; in_tag = 4'he;
      tick();
      in_valid = 1'b0; in_data = 'x; in_inv = 1'bx; in_tag = 'x;
      tick();
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'he || out_data !== IE) begin
         errors++; $display("FAIL rm_resume: got %b/%h/%h want 1/e/%h", out_valid, out_tag, out_data, IE);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_fwd();
      test_inv();
      test_round_trip();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
